// File: rtl/branch_resolve_unit_pkg.sv
// HighLevelControl: shared control-path types for the execute stage.
//   aluOperation    - ALU operation select
//   branchCondition - branch/jump condition select used by branch resolution
// Also provides the machine word width macro XLEN when not already defined.
`ifndef XLEN
`define XLEN 32
`endif

package HighLevelControl;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } aluOperation;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } branchCondition;

endpackage

// File: rtl/branch_resolve_unit_condition_eval.sv
// branch_condition_eval: combinational taken decision from the condition
// select and the flags of SUB rs1-rs2 (Carry is the unsigned borrow).
//   BranchCond         - condition select
//   Zero/oVerflow/Negative/Carry - ALU flags
//   Taken              - branch/jump resolves taken
module branch_condition_eval
  import HighLevelControl::*;
(
  input  branchCondition BranchCond,
  input  logic           Zero,
  input  logic           oVerflow,
  input  logic           Negative,
  input  logic           Carry,
  output logic           Taken
);

  // Signed less-than after a subtract is N xor V.
  logic lt;
  assign lt = Negative ^ oVerflow;

  always_comb begin
    Taken = 1'b0;
    case (BranchCond)
      BEQ:     Taken = Zero;
      BNE:     Taken = ~Zero;
      BLT:     Taken = lt;
      BGE:     Taken = ~lt;
      BLTU:    Taken = Carry;
      BGEU:    Taken = ~Carry;
      JAL:     Taken = 1'b1;
      JALR:    Taken = 1'b1;
      default: Taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch/jump resolution with static
// not-taken prediction. A taken branch registers a one-cycle Redirect to
// RedirectPC and squashes younger stages for FLUSH_DEPTH unstalled cycles.
// Saturating counters track resolved branches and issued redirects.
//   clk, reset (sync, active high), Stall (freezes everything)
//   BranchValid, BranchCond, Zero/oVerflow/Negative/Carry, TargetAddr
//   Redirect, RedirectPC, Squash, BranchCount, TakenCount
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_unit
  import HighLevelControl::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Stall,
  input  logic                 BranchValid,
  input  branchCondition       BranchCond,
  input  logic                 Zero,
  input  logic                 oVerflow,
  input  logic                 Negative,
  input  logic                 Carry,
  input  logic [`XLEN-1:0]     TargetAddr,
  output logic                 Redirect,
  output logic [`XLEN-1:0]     RedirectPC,
  output logic                 Squash,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] TakenCount
);

  typedef enum logic {IDLE, SQUASH} state_t;

  localparam logic [2:0] SQ_INIT = 3'(FLUSH_DEPTH - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t     state, state_next;
  logic [2:0] squash_cnt;
  logic       taken;
  logic       accept;

  branch_condition_eval u_eval (
    .BranchCond (BranchCond),
    .Zero       (Zero),
    .oVerflow   (oVerflow),
    .Negative   (Negative),
    .Carry      (Carry),
    .Taken      (taken)
  );

  // Branches seen while squashing are wrong-path and never accepted.
  assign accept = BranchValid & ~Stall & (state == IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && taken) state_next = SQUASH;
      SQUASH:  if (!Stall && squash_cnt == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Redirect    <= 1'b0;
      RedirectPC  <= '0;
      Squash      <= 1'b0;
      squash_cnt  <= '0;
      BranchCount <= '0;
      TakenCount  <= '0;
    end else if (!Stall) begin
      Squash <= (state_next == SQUASH);
      if (state == SQUASH) begin
        // Redirect is consumed by the first unstalled edge of the squash.
        Redirect <= 1'b0;
        if (squash_cnt != 3'd0) squash_cnt <= squash_cnt - 3'd1;
      end else if (accept) begin
        BranchCount <= sat_inc(BranchCount);
        if (taken) begin
          TakenCount <= sat_inc(TakenCount);
          Redirect   <= 1'b1;
          RedirectPC <= {TargetAddr[`XLEN-1:1], 1'b0};
          squash_cnt <= SQ_INIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// random stimulus, compared against a cycle-level reference built from
// operand arithmetic (signed/unsigned compares) rather than ALU flags.
module tb_branch_resolve_unit;
  import HighLevelControl::*;

  localparam int FD = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           reset, Stall, BranchValid;
  branchCondition BranchCond;
  logic           Zero, oVerflow, Negative, Carry;
  logic [31:0]    TargetAddr;
  logic           Redirect, Squash;
  logic [31:0]    RedirectPC;
  logic [CW-1:0]  BranchCount, TakenCount;

  branch_resolve_unit #(.FLUSH_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .BranchValid(BranchValid),
    .BranchCond(BranchCond), .Zero(Zero), .oVerflow(oVerflow),
    .Negative(Negative), .Carry(Carry), .TargetAddr(TargetAddr),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Squash(Squash),
    .BranchCount(BranchCount), .TakenCount(TakenCount)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  int          m_left = 0;   // squash cycles still to run
  logic        m_red  = 1'b0;
  logic [31:0] m_pc   = '0;
  int          m_bc   = 0;
  int          m_tc   = 0;

  function automatic bit ref_taken(branchCondition c, logic [31:0] a, logic [31:0] b);
    case (c)
      BEQ:     return a == b;
      BNE:     return a != b;
      BLT:     return $signed(a) <  $signed(b);
      BGE:     return $signed(a) >= $signed(b);
      BLTU:    return a <  b;
      BGEU:    return a >= b;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, update the reference, check outputs.
  task automatic step(input logic v, input branchCondition c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] t,
                      input logic st, input logic rs);
    logic [31:0] d;
    d = a - b;
    reset = rs; Stall = st; BranchValid = v; BranchCond = c; TargetAddr = t;
    Zero     = (d == 32'd0);
    Negative = d[31];
    oVerflow = (a[31] != b[31]) && (d[31] != a[31]);
    Carry    = (a < b);
    @(posedge clk);
    if (rs) begin
      m_left = 0; m_red = 0; m_pc = '0; m_bc = 0; m_tc = 0;
    end else if (!st) begin
      if (m_left > 0) begin
        m_left--; m_red = 0;
      end else if (v) begin
        if (m_bc < CMAX) m_bc++;
        if (ref_taken(c, a, b)) begin
          if (m_tc < CMAX) m_tc++;
          m_left = FD; m_red = 1; m_pc = {t[31:1], 1'b0};
        end
      end
    end
    #1;
    chk("redirect",   32'(Redirect),    32'(m_red));
    chk("squash",     32'(Squash),      32'(m_left > 0));
    chk("redirectpc", RedirectPC,       m_pc);
    chk("bcount",     32'(BranchCount), 32'(m_bc));
    chk("tcount",     32'(TakenCount),  32'(m_tc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, BEQ, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, BEQ, 0, 0, 0, 0, 1);
    step(0, BEQ, 0, 0, 0, 0, 1);
    chk("reset_zero_squash", 32'(Squash), 32'd0);

    // BLT -1 < 1 taken to 0x100
    step(1, BLT, 32'hFFFF_FFFF, 32'd1, 32'h100, 0, 0);
    chk("blt_taken_pc", RedirectPC, 32'h100);
    idle(3);
    // BLT 0x7FFFFFFF < -1 not taken (N=1,V=1)
    step(1, BLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h400, 0, 0);
    chk("blt_nt_redirect", 32'(Redirect), 32'd0);
    idle(1);
    // BGEU with no borrow taken; JALR bit-0 clear; BNE with equal operands
    step(1, BGEU, 32'd9, 32'd3, 32'h300, 0, 0);
    idle(3);
    step(1, JALR, 0, 0, 32'h203, 0, 0);
    chk("jalr_pc", RedirectPC, 32'h202);
    idle(3);
    step(1, BNE, 32'd5, 32'd5, 32'h500, 0, 0);
    idle(1);
    // Taken BEQ, wrong-path branches during both squash cycles
    step(1, BEQ, 32'd7, 32'd7, 32'h600, 0, 0);
    step(1, JAL, 0, 0, 32'h700, 0, 0);
    step(1, JAL, 0, 0, 32'h704, 0, 0);
    idle(2);
    // Stall 3 cycles starting in the redirect cycle
    step(1, JAL, 0, 0, 32'h800, 0, 0);
    step(1, JAL, 0, 0, 32'h900, 1, 0);
    step(0, BEQ, 0, 0, 0, 1, 0);
    step(0, BEQ, 0, 0, 0, 1, 0);
    idle(4);
    // Reset mid-squash
    step(1, JAL, 0, 0, 32'hA00, 0, 0);
    step(0, BEQ, 0, 0, 0, 0, 1);
    chk("reset_mid_pc", RedirectPC, 32'd0);
    // Saturate counters: enough taken jumps to pass all-ones
    for (int i = 0; i < CMAX + 2; i++) begin
      step(1, JAL, 0, 0, 32'h1000 + 32'(i * 4), 0, 0);
      idle(FD);
    end
    chk("tcount_sat", 32'(TakenCount), 32'(CMAX));
    // Random traffic
    step(0, BEQ, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) b = 32'h8000_0000;
      step($urandom_range(0, 1), branchCondition'($urandom_range(0, 7)), a, b,
           $urandom(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves conditional branches and jumps in the execute stage from the ALU's SUB result flags (Zero, oVerflow, Negative, Carry). Produces a registered one-cycle fetch redirect and a timed squash of younger pipeline stages. Static not-taken prediction: every taken branch or jump is a mispredict. Sits between the execute-stage ALU and the fetch/decode pipeline registers, and keeps saturating branch/redirect counters for performance reporting.

## Interface
Parameters:
- FLUSH_DEPTH, 2, number of younger stages squashed per redirect (1..7)
- CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Stall  input  1  pipeline stall; when high, all state and outputs hold
- BranchValid  input  1  execute stage holds a branch/jump this cycle
- BranchCond  input  HighLevelControl::branchCondition  BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
- Zero, oVerflow, Negative, Carry  input  1 each  ALU flags from SUB of rs1-rs2 (Carry = unsigned borrow)
- TargetAddr  input  `XLEN  computed target; for JALR, ALU sum before bit-0 clear
- Redirect  output  1  one-cycle pulse: fetch loads RedirectPC
- RedirectPC  output  `XLEN  new fetch address, bit 0 forced to 0
- Squash  output  1  invalidate younger stages
- BranchCount  output  CNT_WIDTH  branches/jumps resolved
- TakenCount  output  CNT_WIDTH  redirects issued

## Operation
- Condition evaluation: BEQ=Zero; BNE=~Zero; BLT=Negative^oVerflow; BGE=~(Negative^oVerflow); BLTU=Carry; BGEU=~Carry; JAL/JALR always taken. Undefined BranchCond encodings are treated as not-taken.
- An accepted branch is a rising edge with BranchValid & ~Stall & state==IDLE.
- FSM states: IDLE, SQUASH.
  - IDLE -> SQUASH on an accepted taken branch. Redirect=1, RedirectPC={TargetAddr[`XLEN-1:1],1'b0} and SquashCnt=FLUSH_DEPTH-1 are registered.
  - IDLE -> IDLE on an accepted not-taken branch: no redirect.
  - SQUASH: Squash=1. SquashCnt decrements each unstalled cycle. At 0 the FSM returns to IDLE.
  - BranchValid in SQUASH is a wrong-path instruction: ignored and not counted.
- Redirect is asserted only in the first SQUASH cycle. If Stall is held, Redirect holds high until the first unstalled edge consumes it.
- Counters: BranchCount increments on every accepted branch. TakenCount increments on accepted taken branches. Both saturate at all-ones and never wrap.
- Reset (at any point, including mid-SQUASH): state=IDLE, Redirect=0, RedirectPC=0, Squash=0, SquashCnt=0, both counters 0.

## Timing
- Latency: branch accepted at edge N -> Redirect and Squash high during cycle N+1. Squash stays high for exactly FLUSH_DEPTH unstalled cycles.
- Outputs are registered with no combinational path from inputs.
- The next branch can be accepted at the edge that ends the final Squash cycle only if state has already returned to IDLE. Back-to-back taken branches therefore accept no sooner than FLUSH_DEPTH+1 cycles apart.
- Stall and reset in the same cycle: reset wins.

## Structure
- The branchCondition enum is added to the HighLevelControl package alongside aluOperation. The FSM state enum stays local.
- One sub-module, branch_condition_eval: purely combinational (BranchCond, flags) -> Taken. It is reusable by a future early-resolution stage in decode.
- The counters are inline, using a saturating-increment function local to the module.

## Test plan
- BLT with rs1=-1, rs2=1 (flags N=1, V=0), TargetAddr=0x100 -> next cycle Redirect=1, RedirectPC=0x100; Squash high 2 cycles; TakenCount=1.
- BLT with rs1=0x7FFFFFFF, rs2=-1 (N=1, V=1) -> not taken, no Redirect; BranchCount=1, TakenCount=0.
- BGEU with Carry=0 and JALR with TargetAddr=0x203 -> RedirectPC=0x202; BNE with Zero=1 -> no redirect.
- Taken BEQ followed by BranchValid=1 on both squash cycles -> both wrong-path branches ignored; counts increase by 1 only.
- Stall held 3 cycles starting in the redirect cycle -> Redirect/Squash/RedirectPC frozen; Squash then runs 2 more unstalled cycles.
- Reset asserted mid-SQUASH -> next cycle all outputs 0; counter preset to all-ones with one more taken branch -> TakenCount stays all-ones.
